shifter_ctrl: RTL and testbench

- Controller for the 8-stage, 4-bit shift line (`si`/`shn`/`so` interface, active-high `rst`).
- Arbitrates two word sources (A, B) into the line with round-robin fairness and generates every `shn` pulse.
- Tracks a shadow valid/source tag per stage and presents the line head to a consumer with a valid/ready handshake.
- Supports backpressure and a flush mode that drains the line with bubbles.

---
 rtl/shifter_ctrl.sv | 126 ++++++++++++
 tb/tb_shifter_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shifter_ctrl.sv
// shifter_ctrl: controller for an external DEPTH-stage, WIDTH-bit shift line.
// Arbitrates sources A and B round-robin into the line, generates every shift
// pulse, tracks a shadow valid/source tag per stage, and presents the line head
// to a consumer through a valid/ready handshake. A flush drains the line with
// bubbles. The line itself is external; drive its active-high reset with ~rst.
module shifter_ctrl #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ready,
    input  logic             flush,
    output logic [WIDTH-1:0] sh_si,
    output logic             sh_shn,
    input  logic [WIDTH-1:0] sh_so,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_src,
    input  logic             out_ready,
    output logic [CW-1:0]    count,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [DEPTH-1:0] vld_q, vld_d;      // shadow valid per stage, [DEPTH-1] is the head
    logic [DEPTH-1:0] src_q, src_d;      // shadow source tag per stage, 1 = B
    logic             rr_q, rr_d;        // source preferred on contention, 1 = B
    logic [CW-1:0]    count_q, count_d;
    logic             busy_q;

    logic head_blk, can_shift, arb_ok;
    logic grant_a, grant_b, accept, pop, drain, shift;

    // Arbitration, shift decision and next-state values for the shadow line.
    // NOTE: every signal gets a default at the top of always_comb so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        head_blk  = vld_q[DEPTH-1] & ~out_ready;
        can_shift = ~head_blk;
        // Gating with rst keeps the combinational readies and shift low in reset.
        arb_ok    = rst & can_shift & (state_q != FLUSH);
        grant_a   = arb_ok & a_valid & (~b_valid | ~rr_q);
        grant_b   = arb_ok & b_valid & (~a_valid |  rr_q);
        accept    = grant_a | grant_b;
        pop       = vld_q[DEPTH-1] & out_ready;
        drain     = (state_q == FLUSH) & (count_q != '0);
        shift     = can_shift & (accept | pop | drain);

        vld_d = vld_q;
        src_d = src_q;
        if (shift) begin
            vld_d = {vld_q[DEPTH-2:0], accept};
            src_d = {src_q[DEPTH-2:0], grant_b};
        end

        // After serving a source, prefer the other one next time.
        rr_d = accept ? grant_a : rr_q;

        unique case ({accept, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = RUN;
            // An empty line returns to IDLE even if a flush arrives the same cycle.
            RUN:     if (count_d == '0) state_d = IDLE;
                     else if (flush)    state_d = FLUSH;
            FLUSH:   if (count_d == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Register FSM state, shadow line, round-robin pointer, count and busy.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            vld_q   <= '0;
            src_q   <= '0;
            rr_q    <= 1'b0;
            count_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vld_q   <= vld_d;
            src_q   <= src_d;
            rr_q    <= rr_d;
            count_q <= count_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    // Line drive: granted word on a shift, otherwise a zero bubble.
    always_comb begin
        sh_si = '0;
        if (grant_b)      sh_si = b_data;
        else if (grant_a) sh_si = a_data;
    end

    assign sh_shn    = shift;
    assign a_ready   = grant_a;
    assign b_ready   = grant_b;
    assign out_valid = vld_q[DEPTH-1];
    assign out_src   = src_q[DEPTH-1];
    assign out_data  = sh_so;
    assign count     = count_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_shifter_ctrl.sv
// tb_shifter_ctrl: drives shifter_ctrl plus a behavioural shift line. A
// reference model predicts grants, shifts and line occupancy each cycle and
// pushes accepted words into a scoreboard queue; a separate monitor pops that
// queue whenever the DUT hands a head word to the consumer.
module tb_shifter_ctrl;

    localparam int DEPTH = 8;
    localparam int WIDTH = 4;
    localparam int CW    = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             a_valid, b_valid, flush, out_ready;
    logic [WIDTH-1:0] a_data, b_data;
    logic             a_ready, b_ready, sh_shn, out_valid, out_src, busy;
    logic [WIDTH-1:0] sh_si, sh_so, out_data;
    logic [CW-1:0]    count;

    always #5 clk = ~clk;

    shifter_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .a_valid   (a_valid),
        .a_data    (a_data),
        .a_ready   (a_ready),
        .b_valid   (b_valid),
        .b_data    (b_data),
        .b_ready   (b_ready),
        .flush     (flush),
        .sh_si     (sh_si),
        .sh_shn    (sh_shn),
        .sh_so     (sh_so),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready),
        .count     (count),
        .busy      (busy)
    );

    // Physical shift line with active-high asynchronous reset.
    logic             line_rst;
    logic [WIDTH-1:0] line_q [DEPTH];
    assign line_rst = ~rst;
    assign sh_so    = line_q[DEPTH-1];

    always @(posedge clk or posedge line_rst) begin
        if (line_rst) begin
            for (int i = 0; i < DEPTH; i++) line_q[i] <= '0;
        end else if (sh_shn) begin
            line_q[0] <= sh_si;
            for (int i = 1; i < DEPTH; i++) line_q[i] <= line_q[i-1];
        end
    end

    // Scoreboard and reference model state.
    typedef struct packed {
        logic [WIDTH-1:0] d;
        logic             s;
    } word_t;

    typedef struct packed {
        logic             v;
        logic [WIDTH-1:0] d;
        logic             s;
    } slot_t;

    word_t exp_q[$];
    slot_t ref_line [DEPTH];
    bit    ref_rr;      // 1 = B preferred on contention
    bit    ref_drain;   // line is being drained by a flush
    int    n_checks = 0;
    int    n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: evaluates each cycle at the falling edge, when inputs are stable.
    initial begin : model
        int    cnt, new_cnt;
        bit    hb, open, ga, gb, acc, pop, sh;
        word_t w;
        ref_rr    = 1'b0;
        ref_drain = 1'b0;
        for (int i = 0; i < DEPTH; i++) ref_line[i] = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("rst_a_ready",   32'(a_ready),   32'd0);
                check("rst_b_ready",   32'(b_ready),   32'd0);
                check("rst_sh_shn",    32'(sh_shn),    32'd0);
                check("rst_out_valid", 32'(out_valid), 32'd0);
                check("rst_count",     32'(count),     32'd0);
                check("rst_busy",      32'(busy),      32'd0);
                check("rst_out_data",  32'(out_data),  32'd0);
                for (int i = 0; i < DEPTH; i++) ref_line[i] = '0;
                ref_rr    = 1'b0;
                ref_drain = 1'b0;
                exp_q.delete();
            end else begin
                cnt = 0;
                for (int i = 0; i < DEPTH; i++) cnt += int'(ref_line[i].v);
                hb   = ref_line[DEPTH-1].v && !out_ready;
                open = !ref_drain && !hb;
                if (a_valid && b_valid) begin
                    ga = open && !ref_rr;
                    gb = open &&  ref_rr;
                end else begin
                    ga = open && a_valid;
                    gb = open && b_valid;
                end
                acc = ga || gb;
                pop = ref_line[DEPTH-1].v && out_ready;
                sh  = !hb && (acc || pop || (ref_drain && cnt != 0));
                w   = gb ? {b_data, 1'b1} : {a_data, 1'b0};

                check("a_ready",   32'(a_ready),   32'(ga));
                check("b_ready",   32'(b_ready),   32'(gb));
                check("sh_shn",    32'(sh_shn),    32'(sh));
                check("sh_si",     32'(sh_si),     acc ? 32'(w.d) : 32'd0);
                check("out_valid", 32'(out_valid), 32'(ref_line[DEPTH-1].v));
                check("count",     32'(count),     32'(cnt));
                check("busy",      32'(busy),      32'(cnt != 0));
                check("out_data_is_so", 32'(out_data), 32'(sh_so));
                if (ref_line[DEPTH-1].v) begin
                    check("head_src_model",  32'(out_src),  32'(ref_line[DEPTH-1].s));
                    check("head_data_model", 32'(out_data), 32'(ref_line[DEPTH-1].d));
                end

                if (acc) begin
                    exp_q.push_back(w);
                    ref_rr = ga;
                end
                if (sh) begin
                    for (int i = DEPTH-1; i > 0; i--) ref_line[i] = ref_line[i-1];
                    ref_line[0] = acc ? {1'b1, w.d, w.s} : '0;
                end
                new_cnt = cnt + int'(acc) - int'(pop);
                if (new_cnt == 0)           ref_drain = 1'b0;
                else if (flush && cnt != 0) ref_drain = 1'b1;
            end
        end
    end

    // Monitor: every completed head handshake must match the oldest accepted word.
    initial begin : monitor
        word_t e;
        forever begin
            @(negedge clk);
            if (rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("pop_with_empty_scoreboard", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_head_data", 32'(out_data), 32'(e.d));
                    check("sb_head_src",  32'(out_src),  32'(e.s));
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic quiet();
        a_valid = 1'b0;
        b_valid = 1'b0;
        flush   = 1'b0;
    endtask

    task automatic flush_pulse(input int settle);
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        step(settle);
    endtask

    initial begin : driver
        bit done;
        // Reset with busy-looking inputs: readies and shift must stay low.
        rst = 1'b0;
        a_valid = 1'b1; b_valid = 1'b1; a_data = 4'h9; b_data = 4'hA;
        flush = 1'b1; out_ready = 1'b1;
        step(3);
        quiet();
        rst = 1'b1;
        step(2);

        // Single A word, no shifts until a flush drains it.
        out_ready = 1'b1;
        a_valid = 1'b1; a_data = 4'h3;
        step(1);
        a_valid = 1'b0;
        step(7);
        check("t1_count_parked", 32'(count), 32'd1);
        flush_pulse(10);
        check("t1_busy_done", 32'(busy), 32'd0);

        // Both sources always valid: alternating grants, line saturates.
        a_valid = 1'b1; b_valid = 1'b1; a_data = 4'h1; b_data = 4'h2;
        step(20);
        check("t2_count_full", 32'(count), 32'd8);

        // Full line with stalled consumer: no shifts, no grants.
        out_ready = 1'b0;
        step(5);
        check("t3_no_shift", 32'(sh_shn), 32'd0);
        check("t3_count",    32'(count),  32'd8);
        out_ready = 1'b1;
        step(3);
        quiet();
        flush_pulse(12);
        check("t3_drained", 32'(count), 32'd0);

        // Three words then flush.
        a_valid = 1'b1;
        a_data = 4'h5; step(1);
        a_data = 4'h6; step(1);
        a_data = 4'h7; step(1);
        a_valid = 1'b0;
        flush_pulse(12);
        check("t4_count", 32'(count), 32'd0);
        check("t4_busy",  32'(busy),  32'd0);

        // Reset while four words are in flight.
        a_valid = 1'b1; a_data = 4'hC;
        step(4);
        check("t5_count_before", 32'(count), 32'd4);
        rst = 1'b0;
        #1;
        check("t5_count_now",   32'(count),   32'd0);
        check("t5_busy_now",    32'(busy),    32'd0);
        check("t5_a_ready_now", 32'(a_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        quiet();
        step(2);
        // Pointer restarts at A.
        a_valid = 1'b1; b_valid = 1'b1; a_data = 4'hD; b_data = 4'hE;
        #1;
        check("t5_rr_a_first", 32'(a_ready), 32'd1);
        step(1);
        quiet();
        flush_pulse(12);

        // Flush in IDLE is ignored.
        flush = 1'b1;
        #1;
        check("t6_no_shift", 32'(sh_shn), 32'd0);
        step(1);
        flush = 1'b0;
        step(2);
        check("t6_busy", 32'(busy), 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            a_valid   = ($urandom_range(0, 99) < 55);
            b_valid   = ($urandom_range(0, 99) < 55);
            a_data    = 4'($urandom);
            b_data    = 4'($urandom);
            out_ready = ($urandom_range(0, 99) < 70);
            flush     = ($urandom_range(0, 99) < 3);
            step(1);
        end

        // Final drain with a bounded wait.
        quiet();
        out_ready = 1'b1;
        flush_pulse(0);
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            if (!busy && count == '0) done = 1'b1;
            else step(1);
        end
        check("final_drain", 32'(done), 32'd1);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
